mpu_i2c_responder: RTL and testbench
====================================

// Module: mpu_i2c_responder
// PURPOSE
// I2C target (responder) emulating the MPU register interface: the far end of the I2C master bus.
// Decodes START/STOP, matches the 7-bit device address, keeps an 8-bit register pointer and maps
// bus writes/reads onto a simple register-file port. Used for HIL test and bench loop-back of the master.
// PARAMETERS
// DEVICE_ADDR  7'h68  7-bit bus address answered (MPU 7'b1101000)
// PORTS
// CLK        in   1  system clock; SCL half-period must be >= 8 CLK cycles
// rst        in   1  asynchronous reset, active-high
// SCL_IN     in   1  bus clock from pad (asynchronous to CLK)
// SDA_IN     in   1  bus data from pad (asynchronous to CLK)
// SDA_OUT    out  1  constant 0 (open-drain: only ever pulls low)
// SDA_DIR    out  1  1 = pull SDA low, 0 = release
// REG_ADDR   out  8  register pointer
// REG_WEN    out  1  1-CLK pulse: write REG_WDATA to REG_ADDR
// REG_WDATA  out  8  write data, valid while REG_WEN high
// REG_REN    out  1  1-CLK pulse: request read of REG_ADDR
// REG_RDATA  in   8  read data, must be valid on the CLK after REG_REN
// BUSY       out  1  high from own-address ACK until STOP / next START
// BEHAVIOUR
// - Reset: SDA_OUT=0, SDA_DIR=0, REG_ADDR=0, REG_WEN=0, REG_WDATA=0, REG_REN=0, BUSY=0, state IDLE.
// - SCL_IN/SDA_IN through 2-FF synchronisers; edges from synced values (2-3 CLK latency).
// - START = SDA fall while SCL high; STOP = SDA rise while SCL high; both take priority over bit sampling.
// - Bits sampled on synced SCL rise, MSB first; SDA_DIR changes only on synced SCL fall.
// - States: IDLE, DEV_ADDR, ADDR_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
// - START in any state -> DEV_ADDR, bit cnt 0, SDA released (repeated start keeps REG_ADDR).
// - STOP in any state -> IDLE, SDA released, BUSY=0. REG_ADDR retained.
// - DEV_ADDR: 8 bits; addr match -> ADDR_ACK (pull SDA low for 9th clock), else IGNORE (never drive).
// - After ACK of addr+W -> REG_ADDR; byte loaded into REG_ADDR, ACK, then WR_DATA.
// - WR_DATA: after 8th bit REG_WEN pulses once with REG_WDATA, ACK, REG_ADDR+1 (8-bit wrap FF->00).
// - addr+R: REG_REN pulses at SCL rise of ACK bit; REG_RDATA captured next CLK into shift reg;
//   bit7 driven at SCL fall ending ACK; SDA_DIR = ~bit (release for 1, pull for 0).
// - RD_DATA -> RD_ACK after 8 bits (SDA released). Master ACK(0): REG_ADDR+1, REG_REN at that SCL
//   rise, next byte. Master NACK(1): -> IGNORE until STOP/START.
// - REG_ADDR increments once per byte transferred, after the REG_WEN / REG_REN of that byte.
// - No clock stretching; SCL never driven. Bytes after STOP/START mid-byte are discarded (no REG_WEN).
// - rst mid-transaction releases SDA asynchronously; block resyncs at next START.
// TESTING
// 1 START,D0,6B,01,02,STOP -> 4 ACKs; REG_WEN @6B=01, @6C=02; final REG_ADDR=6D; BUSY low after STOP.
// 2 START,D0,3B,RSTART,D1, read 14 bytes (ACK x13, NACK), STOP; model REG[n]=n -> bytes 3B..48, 14 REG_REN.
// 3 START,A0,xx,STOP -> SDA_DIR never 1, no REG_WEN/REG_REN, BUSY stays 0.
// 4 REG_ADDR=FF, write 2 bytes AA,BB -> REG_WEN @FF=AA, @00=BB (wrap).
// 5 STOP after 4 data bits of a write -> no REG_WEN, state IDLE; next full write accepted normally.
// 6 rst asserted while driving a 0 read bit -> SDA_DIR=0 same cycle; all outputs at reset values.

Source files
------------

// File: rtl/mpu_i2c_responder.sv
// mpu_i2c_responder
// I2C target that emulates the MPU register interface so the I2C master can be
// exercised in HIL and loop-back setups. It detects START/STOP, answers one 7-bit
// device address, keeps an auto-incrementing 8-bit register pointer, and turns bus
// writes and reads into single-cycle strobes on a simple register-file port.
//
// Ports
//   CLK        system clock (SCL half-period must be at least 8 CLK cycles)
//   rst        asynchronous reset, active-high
//   SCL_IN     bus clock from the pad, asynchronous to CLK
//   SDA_IN     bus data from the pad, asynchronous to CLK
//   SDA_OUT    tied to 0; the pad is open-drain and only ever pulls low
//   SDA_DIR    1 = pull SDA low, 0 = release
//   REG_ADDR   register pointer
//   REG_WEN    one-cycle write strobe (REG_WDATA -> REG_ADDR)
//   REG_WDATA  write data, valid while REG_WEN is high
//   REG_REN    one-cycle read request for REG_ADDR
//   REG_RDATA  read data, valid on the CLK after REG_REN
//   BUSY       high from own-address ACK until STOP or the next START

module mpu_i2c_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h68
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  output logic       SDA_DIR,
  output logic [7:0] REG_ADDR,
  output logic       REG_WEN,
  output logic [7:0] REG_WDATA,
  output logic       REG_REN,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ADDR_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync;
  logic [1:0]  sda_sync;
  logic        scl_prev;
  logic        sda_prev;
  logic        scl;
  logic        sda;
  logic        scl_rise;
  logic        scl_fall;
  logic        start_cond;
  logic        stop_cond;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [7:0]  byte_in;
  logic [7:0]  rd_shift;
  logic        rw;
  logic        ack_rise;
  logic        rd_load;

  assign SDA_OUT = 1'b0;

  // Two-flop synchronisers plus one history flop for edge detection. They reset
  // to 1 because an idle bus floats high.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL_IN};
      sda_sync <= {sda_sync[0], SDA_IN};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl        = scl_sync[1];
  assign sda        = sda_sync[1];
  assign scl_rise   = scl & ~scl_prev;
  assign scl_fall   = ~scl & scl_prev;
  // SDA may only move while SCL is low during data; any SDA edge with SCL held
  // high is a bus condition rather than a bit.
  assign start_cond = scl & scl_prev & sda_prev & ~sda;
  assign stop_cond  = scl & scl_prev & ~sda_prev & sda;
  assign byte_in    = {shift, sda};

  // Protocol FSM. ACK states span two SCL falls: the first (ending the 8th bit)
  // pulls SDA low, the second (ending the ACK clock) hands over to the next byte.
  // ack_rise records that the ACK clock's rising edge has been seen so the two
  // falls can be told apart. The pointer advances the cycle after a write strobe,
  // or when read data is captured, so it is stable while the register file uses it.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      SDA_DIR   <= 1'b0;
      REG_ADDR  <= 8'h00;
      REG_WEN   <= 1'b0;
      REG_WDATA <= 8'h00;
      REG_REN   <= 1'b0;
      BUSY      <= 1'b0;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      rd_shift  <= 8'h00;
      rw        <= 1'b0;
      ack_rise  <= 1'b0;
      rd_load   <= 1'b0;
    end else begin
      REG_WEN <= 1'b0;
      REG_REN <= 1'b0;
      rd_load <= REG_REN;

      if (REG_WEN) begin
        REG_ADDR <= REG_ADDR + 8'd1;
      end
      if (rd_load) begin
        rd_shift <= REG_RDATA;
        REG_ADDR <= REG_ADDR + 8'd1;
      end

      if (start_cond) begin
        state   <= ST_DEV_ADDR;
        bit_cnt <= 3'd0;
        SDA_DIR <= 1'b0;
        BUSY    <= 1'b0;
      end else if (stop_cond) begin
        state   <= ST_IDLE;
        SDA_DIR <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          ST_DEV_ADDR: begin
            if (scl_rise) begin
              shift   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_in[7:1] == DEVICE_ADDR) begin
                  rw       <= byte_in[0];
                  ack_rise <= 1'b0;
                  BUSY     <= 1'b1;
                  state    <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_rise <= 1'b0;
                if (state == ST_REG_ADDR) begin
                  REG_ADDR <= byte_in;
                  state    <= ST_REG_ACK;
                end else begin
                  REG_WDATA <= byte_in;
                  REG_WEN   <= 1'b1;
                  state     <= ST_WR_ACK;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (scl_rise) begin
              ack_rise <= 1'b1;
              if (state == ST_ADDR_ACK && rw) begin
                REG_REN <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_rise) begin
                SDA_DIR <= 1'b1;
              end else begin
                bit_cnt <= 3'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  SDA_DIR <= ~rd_shift[7];
                  state   <= ST_RD_DATA;
                end else begin
                  SDA_DIR <= 1'b0;
                  state   <= (state == ST_ADDR_ACK) ? ST_REG_ADDR : ST_WR_DATA;
                end
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_rise <= 1'b0;
                state    <= ST_RD_ACK;
              end
            end else if (scl_fall) begin
              rd_shift <= {rd_shift[6:0], 1'b0};
              SDA_DIR  <= ~rd_shift[6];
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              ack_rise <= 1'b1;
              if (sda) begin
                state <= ST_IGNORE;
              end else begin
                REG_REN <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_rise) begin
                SDA_DIR <= 1'b0;
              end else begin
                bit_cnt <= 3'd0;
                SDA_DIR <= ~rd_shift[7];
                state   <= ST_RD_DATA;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpu_i2c_responder.sv
// tb_mpu_i2c_responder
// Bit-bangs an I2C master against mpu_i2c_responder over an open-drain bus model.
// Expected register writes, read requests and read bytes are queued as each
// transaction is driven and compared against what the DUT produced.

module tb_mpu_i2c_responder;

  localparam time T = 60;

  logic       CLK = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       SDA_OUT;
  logic       SDA_DIR;
  logic [7:0] REG_ADDR;
  logic       REG_WEN;
  logic [7:0] REG_WDATA;
  logic       REG_REN;
  logic [7:0] reg_rdata;
  logic       BUSY;

  int tests_run    = 0;
  int tests_failed = 0;

  // Open-drain bus: either side can pull low.
  assign sda_bus = sda_m & ~SDA_DIR;

  always #5 CLK = ~CLK;

  mpu_i2c_responder #(.DEVICE_ADDR(7'h68)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .SCL_IN    (scl),
    .SDA_IN    (sda_bus),
    .SDA_OUT   (SDA_OUT),
    .SDA_DIR   (SDA_DIR),
    .REG_ADDR  (REG_ADDR),
    .REG_WEN   (REG_WEN),
    .REG_WDATA (REG_WDATA),
    .REG_REN   (REG_REN),
    .REG_RDATA (reg_rdata),
    .BUSY      (BUSY)
  );

  // Register file model: REG[n] = n, registered read.
  always @(posedge CLK) begin
    if (REG_REN) reg_rdata <= REG_ADDR;
  end

  // Monitor: log every strobe the DUT produces, plus activity counters.
  logic [15:0] obs_wr [0:63];
  logic [7:0]  obs_rd [0:63];
  int obs_wr_n  = 0;
  int obs_rd_n  = 0;
  int dir_hi_n  = 0;
  int busy_hi_n = 0;

  always @(negedge CLK) begin
    if (REG_WEN && obs_wr_n < 64) begin
      obs_wr[obs_wr_n] <= {REG_ADDR, REG_WDATA};
      obs_wr_n <= obs_wr_n + 1;
    end
    if (REG_REN && obs_rd_n < 64) begin
      obs_rd[obs_rd_n] <= REG_ADDR;
      obs_rd_n <= obs_rd_n + 1;
    end
    if (SDA_DIR) dir_hi_n <= dir_hi_n + 1;
    if (BUSY) busy_hi_n <= busy_hi_n + 1;
  end

  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  exp_byte [$];
  int wr_idx = 0;
  int rd_idx = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #T;
    scl = 1'b1;   #T;
    sda_m = 1'b0; #T;
    scl = 1'b0;   #T;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #T;
    scl = 1'b1;   #T;
    sda_m = 1'b1; #T;
  endtask

  task automatic bus_write_bit(input logic b);
    sda_m = b;  #T;
    scl = 1'b1; #(2 * T);
    scl = 1'b0; #T;
  endtask

  task automatic bus_read_bit(output logic b);
    sda_m = 1'b1; #T;
    scl = 1'b1;   #T;
    b = sda_bus;  #T;
    scl = 1'b0;   #T;
  endtask

  // Sends a byte and returns the ACK bit seen on the bus (0 = ACK).
  task automatic bus_write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bus_write_bit(d[i]);
    bus_read_bit(ack);
  endtask

  task automatic bus_read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bus_read_bit(b);
      d[i] = b;
    end
    bus_write_bit(nack);
  endtask

  // Complete write transaction of one or two data bytes, queueing expected writes.
  task automatic applyStimulus(input logic [7:0] reg_ptr, input logic [7:0] d0,
                               input logic [7:0] d1, input int nbytes);
    logic ack;
    bus_start();
    bus_write_byte(8'hD0, ack);
    checkOutput("wr_dev_ack", ack, 1'b0);
    bus_write_byte(reg_ptr, ack);
    checkOutput("wr_reg_ack", ack, 1'b0);
    exp_wr.push_back({reg_ptr, d0});
    bus_write_byte(d0, ack);
    checkOutput("wr_data0_ack", ack, 1'b0);
    if (nbytes > 1) begin
      exp_wr.push_back({reg_ptr + 8'd1, d1});
      bus_write_byte(d1, ack);
      checkOutput("wr_data1_ack", ack, 1'b0);
    end
    bus_stop();
    #(4 * T);
  endtask

  task automatic drainScoreboard();
    logic [15:0] ew;
    logic [7:0]  er;
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      if (wr_idx < obs_wr_n) begin
        checkOutput("reg_write", obs_wr[wr_idx], ew);
        wr_idx++;
      end else begin
        checkOutput("reg_write_count", obs_wr_n, wr_idx + 1);
      end
    end
    checkOutput("no_extra_writes", obs_wr_n, wr_idx);
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front();
      if (rd_idx < obs_rd_n) begin
        checkOutput("reg_read_addr", obs_rd[rd_idx], er);
        rd_idx++;
      end else begin
        checkOutput("reg_read_count", obs_rd_n, rd_idx + 1);
      end
    end
    checkOutput("no_extra_reads", obs_rd_n, rd_idx);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         dir0, busy0;

    scl = 1'b1;
    sda_m = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge CLK);
    #2 rst = 1'b0;
    #20;

    // Reset state
    checkOutput("rst_sda_dir", SDA_DIR, 1'b0);
    checkOutput("rst_sda_out", SDA_OUT, 1'b0);
    checkOutput("rst_reg_addr", REG_ADDR, 8'h00);
    checkOutput("rst_strobes", {REG_WEN, REG_REN}, 2'b00);
    checkOutput("rst_wdata", REG_WDATA, 8'h00);
    checkOutput("rst_busy", BUSY, 1'b0);

    // 1: two-byte write at 6B, BUSY after address ACK and cleared by STOP
    bus_start();
    bus_write_byte(8'hD0, ack);
    checkOutput("t1_dev_ack", ack, 1'b0);
    checkOutput("t1_busy_set", BUSY, 1'b1);
    bus_write_byte(8'h6B, ack);
    checkOutput("t1_reg_ack", ack, 1'b0);
    exp_wr.push_back(16'h6B01);
    exp_wr.push_back(16'h6C02);
    bus_write_byte(8'h01, ack);
    checkOutput("t1_d0_ack", ack, 1'b0);
    bus_write_byte(8'h02, ack);
    checkOutput("t1_d1_ack", ack, 1'b0);
    bus_stop();
    #(4 * T);
    checkOutput("t1_final_addr", REG_ADDR, 8'h6D);
    checkOutput("t1_busy_clear", BUSY, 1'b0);
    drainScoreboard();

    // 2: pointer 3B, repeated start, burst read of 14 bytes
    bus_start();
    bus_write_byte(8'hD0, ack);
    checkOutput("t2_dev_w_ack", ack, 1'b0);
    bus_write_byte(8'h3B, ack);
    checkOutput("t2_reg_ack", ack, 1'b0);
    bus_start();
    for (int i = 0; i < 14; i++) begin
      exp_rd.push_back(8'h3B + 8'(i));
      exp_byte.push_back(8'h3B + 8'(i));
    end
    bus_write_byte(8'hD1, ack);
    checkOutput("t2_dev_r_ack", ack, 1'b0);
    for (int i = 0; i < 14; i++) begin
      bus_read_byte(d, (i == 13));
      checkOutput("t2_read_byte", d, exp_byte.pop_front());
    end
    bus_stop();
    #(4 * T);
    checkOutput("t2_sda_released", SDA_DIR, 1'b0);
    drainScoreboard();

    // 3: foreign address is never acknowledged or acted on
    dir0 = dir_hi_n;
    busy0 = busy_hi_n;
    bus_start();
    bus_write_byte(8'hA0, ack);
    checkOutput("t3_nack", ack, 1'b1);
    bus_write_byte(8'h55, ack);
    bus_stop();
    #(4 * T);
    checkOutput("t3_sda_dir_cycles", dir_hi_n - dir0, 0);
    checkOutput("t3_busy_cycles", busy_hi_n - busy0, 0);
    drainScoreboard();

    // 4: pointer wraps FF -> 00
    applyStimulus(8'hFF, 8'hAA, 8'hBB, 2);
    checkOutput("t4_final_addr", REG_ADDR, 8'h01);
    drainScoreboard();

    // 5: STOP after 4 data bits discards the byte, then a normal write
    bus_start();
    bus_write_byte(8'hD0, ack);
    bus_write_byte(8'h10, ack);
    for (int i = 0; i < 4; i++) bus_write_bit(i[0]);
    bus_stop();
    #(4 * T);
    checkOutput("t5_addr_kept", REG_ADDR, 8'h10);
    checkOutput("t5_busy_clear", BUSY, 1'b0);
    drainScoreboard();
    applyStimulus(8'h20, 8'h5A, 8'h00, 1);
    checkOutput("t5_after_addr", REG_ADDR, 8'h21);
    drainScoreboard();

    // 6: reset while driving a 0 read bit (REG[21]=0x21, bit7 = 0)
    bus_start();
    exp_rd.push_back(8'h21);
    bus_write_byte(8'hD1, ack);
    checkOutput("t6_dev_ack", ack, 1'b0);
    checkOutput("t6_driving_low", SDA_DIR, 1'b1);
    @(posedge CLK);
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_sda_dir", SDA_DIR, 1'b0);
    checkOutput("t6_rst_reg_addr", REG_ADDR, 8'h00);
    checkOutput("t6_rst_busy", BUSY, 1'b0);
    checkOutput("t6_rst_strobes", {REG_WEN, REG_REN}, 2'b00);
    repeat (3) @(posedge CLK);
    #2 rst = 1'b0;
    bus_stop();
    #(4 * T);
    drainScoreboard();
    applyStimulus(8'h30, 8'h77, 8'h00, 1);
    checkOutput("t6_resync_addr", REG_ADDR, 8'h31);
    drainScoreboard();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
